// File: rtl/cam_config_seq.sv
`timescale 1ns/1ps
// OV7670 power-up and register-configuration sequencer.
// Drives PWDN/RESET through a timed power-on, then streams {reg,value} ROM entries to the SCCB master.
module cam_config_seq #(
  parameter int          ADDR_W       = 8,
  parameter int unsigned RESET_CYCLES = 25000,
  parameter int unsigned BOOT_CYCLES  = 250000,
  parameter int unsigned DELAY_CYCLES = 250000,
  parameter int          MAX_RETRY    = 3,
  parameter logic [7:0]  DEV_ADDR     = 8'h42
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_dev,
  output logic [7:0]        cmd_reg,
  output logic [7:0]        cmd_val,
  input  logic              wr_done,
  input  logic              wr_nack,
  output logic              cam_reset_n,
  output logic              cam_pwdn,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [3:0]        dbg_state
);

  // Command channel: cmd_dev/cmd_reg/cmd_val are stable whenever cmd_valid is high,
  // a transfer happens on the clock edge where cmd_valid && cmd_ready, and cmd_valid
  // drops the cycle after; cmd_ready with cmd_valid low is ignored.
  typedef enum logic [3:0] {
    S_IDLE,
    S_PWR_RST,
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_ACK,
    S_DELAY,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [31:0] RESET_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] BOOT_LAST  = 32'(BOOT_CYCLES - 1);
  localparam logic [31:0] DELAY_LAST = 32'(DELAY_CYCLES - 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  state_t              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [7:0]          cmd_reg_q, cmd_reg_d;
  logic [7:0]          cmd_val_q, cmd_val_d;
  logic                cam_reset_n_q, cam_reset_n_d;
  logic                cam_pwdn_q, cam_pwdn_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                advance;
  logic                finish;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    rom_addr_d    = rom_addr_q;
    fail_addr_d   = fail_addr_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_reg_d     = cmd_reg_q;
    cmd_val_d     = cmd_val_q;
    cam_reset_n_d = cam_reset_n_q;
    cam_pwdn_d    = cam_pwdn_q;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    advance       = 1'b0;
    finish        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d       = S_PWR_RST;
          cnt_d         = '0;
          retry_d       = '0;
          rom_addr_d    = '0;
          fail_addr_d   = '0;
          cmd_valid_d   = 1'b0;
          cam_reset_n_d = 1'b0;
          cam_pwdn_d    = 1'b0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          error_d       = 1'b0;
        end
      end
      S_PWR_RST: begin
        if (cnt_q == RESET_LAST) begin
          state_d       = S_BOOT;
          cnt_d         = '0;
          cam_reset_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      // The ROM registers rom_addr at the end of FETCH, so DECODE sees its word.
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (rom_data == END_MARK) begin
          finish = 1'b1;
        end else if (rom_data == DELAY_MARK) begin
          state_d = S_DELAY;
          cnt_d   = '0;
        end else begin
          state_d     = S_ISSUE;
          cmd_reg_d   = rom_data[15:8];
          cmd_val_d   = rom_data[7:0];
          retry_d     = '0;
          cmd_valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          state_d     = S_WAIT_ACK;
          cmd_valid_d = 1'b0;
        end
      end
      S_WAIT_ACK: begin
        if (wr_done) begin
          if (!wr_nack) begin
            advance = 1'b1;
          end else if (retry_q < RETRY_MAX) begin
            state_d     = S_ISSUE;
            retry_d     = retry_q + RETRY_W'(1);
            cmd_valid_d = 1'b1;
          end else begin
            state_d     = S_FAIL;
            fail_addr_d = rom_addr_q;
            error_d     = 1'b1;
            busy_d      = 1'b0;
            cam_pwdn_d  = 1'b1;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The table never wraps: the last ROM slot ends the sequence like an end marker.
    if (advance) begin
      if (rom_addr_q == ADDR_LAST) begin
        finish = 1'b1;
      end else begin
        state_d    = S_FETCH;
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        cnt_d      = '0;
      end
    end

    if (finish) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      retry_q       <= '0;
      rom_addr_q    <= '0;
      fail_addr_q   <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_reg_q     <= '0;
      cmd_val_q     <= '0;
      cam_reset_n_q <= 1'b0;
      cam_pwdn_q    <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      rom_addr_q    <= rom_addr_d;
      fail_addr_q   <= fail_addr_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_reg_q     <= cmd_reg_d;
      cmd_val_q     <= cmd_val_d;
      cam_reset_n_q <= cam_reset_n_d;
      cam_pwdn_q    <= cam_pwdn_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_dev     = DEV_ADDR;
  assign cmd_reg     = cmd_reg_q;
  assign cmd_val     = cmd_val_q;
  assign cam_reset_n = cam_reset_n_q;
  assign cam_pwdn    = cam_pwdn_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign fail_addr   = fail_addr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cam_config_seq.sv
`timescale 1ns/1ps
// Bench for cam_config_seq: ROM + SCCB responder, table-walk model, per-cycle compare process.
module tb_cam_config_seq;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int RST_C  = 4;
  localparam int BOOT_C = 8;
  localparam int DLY_C  = 10;
  localparam int MAX_R  = 3;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_dev;
  logic [7:0]        cmd_reg;
  logic [7:0]        cmd_val;
  logic              wr_done;
  logic              wr_nack;
  logic              cam_reset_n;
  logic              cam_pwdn;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] fail_addr;
  logic [3:0]        dbg_state;

  cam_config_seq #(
    .ADDR_W(ADDR_W), .RESET_CYCLES(RST_C), .BOOT_CYCLES(BOOT_C),
    .DELAY_CYCLES(DLY_C), .MAX_RETRY(MAX_R), .DEV_ADDR(8'h42)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev), .cmd_reg(cmd_reg),
    .cmd_val(cmd_val), .wr_done(wr_done), .wr_nack(wr_nack), .cam_reset_n(cam_reset_n),
    .cam_pwdn(cam_pwdn), .busy(busy), .done(done), .error(error), .fail_addr(fail_addr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // synchronous ROM
  logic [15:0] rom_mem [DEPTH];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'hFFFF;
  endtask

  // SCCB responder
  int ready_delay = 0;
  int ack_lat = 2;
  bit nack_script[$];

  initial begin
    cmd_ready = 1'b0;
    wr_done   = 1'b0;
    wr_nack   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && cmd_valid) begin
        for (int i = 0; i < ready_delay && reset; i++) @(negedge clk);
        if (reset) begin
          cmd_ready = 1'b1;
          @(negedge clk);
          cmd_ready = 1'b0;
          for (int j = 0; j < ack_lat && reset; j++) @(negedge clk);
          if (reset) begin
            wr_done = 1'b1;
            wr_nack = (nack_script.size() > 0) ? nack_script.pop_front() : 1'b0;
            @(negedge clk);
            wr_done = 1'b0;
            wr_nack = 1'b0;
          end
        end
      end
    end
  end

  // model: walk the table, list the commands expected and the final outcome
  logic [15:0]       exp_q[$];
  logic [15:0]       got_q[$];
  bit                exp_done;
  bit                exp_error;
  logic [ADDR_W-1:0] exp_fail;

  task automatic run_model();
    int  idx;
    int  pos;
    bit  fin;
    bit  ok;
    bit  nk;
    logic [15:0] w;
    exp_q.delete();
    exp_done = 1'b0; exp_error = 1'b0; exp_fail = '0;
    idx = 0; pos = 0; fin = 1'b0;
    while (!fin) begin
      w = rom_mem[idx];
      if (w == 16'hFFFF) begin
        exp_done = 1'b1; fin = 1'b1;
      end else begin
        if (w != 16'hFFF0) begin
          ok = 1'b0;
          for (int t = 0; t <= MAX_R && !ok; t++) begin
            exp_q.push_back(w);
            nk = (pos < nack_script.size()) ? nack_script[pos] : 1'b0;
            pos++;
            if (!nk) ok = 1'b1;
          end
          if (!ok) begin
            exp_error = 1'b1; exp_fail = ADDR_W'(idx); fin = 1'b1;
          end
        end
        if (!fin) begin
          if (idx == DEPTH - 1) begin
            exp_done = 1'b1; fin = 1'b1;
          end else begin
            idx++;
          end
        end
      end
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_reg", 32'(cmd_reg), 0);
    chk("rst_cmd_val", 32'(cmd_val), 0);
    chk("rst_cam_reset_n", 32'(cam_reset_n), 0);
    chk("rst_cam_pwdn", 32'(cam_pwdn), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_fail_addr", 32'(fail_addr), 0);
  endtask

  // compare process: one pass per cycle, sampled 1 ns after the rising edge
  bit                seq_on = 1'b0;
  int                k = 0;
  int                st_kind = 0;
  logic [ADDR_W-1:0] st_fail = '0;

  initial begin
    logic       p_start, p_valid, p_ready;
    logic [7:0] p_reg, p_val;
    forever begin
      @(posedge clk);
      p_start = start; p_valid = cmd_valid; p_ready = cmd_ready;
      p_reg = cmd_reg; p_val = cmd_val;
      #1;
      chk("cmd_dev", 32'(cmd_dev), 32'h42);
      if (!reset) begin
        seq_on = 1'b0;
        st_kind = 0;
        check_reset_vals();
      end else begin
        if (p_start && !seq_on) begin
          seq_on = 1'b1;
          k = 0;
        end
        if (seq_on) k++;
        if (p_valid && p_ready) begin
          if (exp_q.size() == 0) chk("extra_cmd", {p_reg, p_val}, 32'hFFFF_FFFF);
          else chk("cmd_word", {p_reg, p_val}, exp_q.pop_front());
          got_q.push_back({p_reg, p_val});
          chk("valid_drop", 32'(cmd_valid), 0);
        end else if (p_valid) begin
          chk("valid_hold", 32'(cmd_valid), 1);
          chk("reg_hold", 32'(cmd_reg), 32'(p_reg));
          chk("val_hold", 32'(cmd_val), 32'(p_val));
        end
        if (seq_on && (done || error)) begin
          chk("end_done", 32'(done), 32'(exp_done));
          chk("end_error", 32'(error), 32'(exp_error));
          chk("end_busy", 32'(busy), 0);
          chk("cmds_left", exp_q.size(), 0);
          if (exp_error) begin
            chk("fail_addr", 32'(fail_addr), 32'(exp_fail));
            chk("fail_pwdn", 32'(cam_pwdn), 1);
            st_kind = 2; st_fail = exp_fail;
          end else begin
            chk("done_pins", {cam_pwdn, cam_reset_n}, 32'b01);
            st_kind = 1;
          end
          seq_on = 1'b0;
        end else if (seq_on) begin
          chk("busy_run", 32'(busy), 1);
          chk("status_run", {done, error}, 0);
          chk("pwdn_run", 32'(cam_pwdn), 0);
          if (k <= RST_C) begin
            chk("cam_rst_low", 32'(cam_reset_n), 0);
            chk("no_cmd_pwr", 32'(cmd_valid), 0);
          end else begin
            chk("cam_rst_high", 32'(cam_reset_n), 1);
            if (k <= RST_C + BOOT_C) chk("no_cmd_boot", 32'(cmd_valid), 0);
          end
        end else begin
          chk("busy_idle", 32'(busy), 0);
          chk("valid_idle", 32'(cmd_valid), 0);
          case (st_kind)
            1: chk("done_hold", {done, error, cam_pwdn, cam_reset_n}, 32'b1001);
            2: begin
              chk("fail_hold", {done, error, cam_pwdn}, 32'b011);
              chk("fail_addr_hold", 32'(fail_addr), 32'(st_fail));
            end
            default: chk("idle_hold", {done, error, cam_pwdn, cam_reset_n}, 32'b0010);
          endcase
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_seq_end(input int budget);
    int n = 0;
    while (seq_on && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("seq_timeout", 32'(seq_on), 0);
  endtask

  task automatic prep(input bit fresh_script);
    if (fresh_script) nack_script.delete();
    run_model();
    got_q.delete();
  endtask

  initial begin
    int n;
    int m;
    reset = 1'b0;
    start = 1'b0;
    clear_rom();
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // two writes then end marker; power-up timing
    clear_rom();
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1114; rom_mem[2] = 16'hFFFF;
    prep(1);
    pulse_start();
    n = 0;
    while (!cam_reset_n && n < 100) begin n++; @(negedge clk); end
    chk("t1_rst_low_cycles", n, RST_C);
    n = 0;
    while (!cmd_valid && n < 100) begin @(negedge clk); n++; end
    chk("t1_boot_to_cmd", n, BOOT_C + 2);
    chk("t1_first_addr", 32'(rom_addr), 0);
    wait_seq_end(500);
    repeat (5) @(negedge clk);
    chk("t1_cmd_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t1_cmd0", 32'(got_q[0]), 32'h1280);
      chk("t1_cmd1", 32'(got_q[1]), 32'h1114);
    end
    chk("t1_done_busy", {done, busy}, 32'b10);

    // delay marker
    clear_rom();
    rom_mem[0] = 16'hFFF0; rom_mem[1] = 16'h3A04; rom_mem[2] = 16'hFFFF;
    prep(1);
    pulse_start();
    n = 0;
    while (!cam_reset_n && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (rom_addr != 3'd1 && n < 100) begin @(negedge clk); n++; end
    chk("t2_addr1_time", n, BOOT_C + 2 + DLY_C);
    m = 0;
    while (!cmd_valid && m < 100) begin @(negedge clk); m++; end
    chk("t2_cmd_after_fetch", m, 2);
    wait_seq_end(500);
    chk("t2_cmd_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("t2_cmd0", 32'(got_q[0]), 32'h3A04);

    // slow cmd_ready
    clear_rom();
    rom_mem[0] = 16'h1280;
    prep(1);
    ready_delay = 5;
    pulse_start();
    n = 0;
    while (!cmd_valid && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (cmd_valid && n < 50) begin n++; @(negedge clk); end
    chk("t3_valid_cycles", n, 6);
    wait_seq_end(500);
    ready_delay = 0;

    // NACK twice then ACK
    clear_rom();
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1114;
    nack_script = '{1'b1, 1'b1, 1'b0};
    prep(0);
    pulse_start();
    wait_seq_end(800);
    chk("t4_cmd_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("t4_retry_a", 32'(got_q[0]), 32'h1280);
      chk("t4_retry_c", 32'(got_q[2]), 32'h1280);
      chk("t4_next", 32'(got_q[3]), 32'h1114);
    end
    chk("t4_done", 32'(done), 1);

    // second entry always NACKs
    nack_script = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    prep(0);
    pulse_start();
    wait_seq_end(800);
    chk("t5_cmd_count", got_q.size(), 5);
    chk("t5_error", {error, done, busy}, 32'b100);
    chk("t5_fail_addr", 32'(fail_addr), 1);
    chk("t5_pwdn", 32'(cam_pwdn), 1);

    // full table with no end marker: stops at the last slot
    clear_rom();
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'h2000 | 16'(i << 8) | 16'(i << 4);
    prep(1);
    pulse_start();
    wait_seq_end(1500);
    chk("t6_cmd_count", got_q.size(), DEPTH);
    if (got_q.size() == DEPTH) chk("t6_last_cmd", 32'(got_q[DEPTH-1]), 32'h2770);
    chk("t6_last_addr", 32'(rom_addr), 7);
    chk("t6_done", 32'(done), 1);

    // reset while waiting for the acknowledge, then rerun with a start while busy
    clear_rom();
    rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1114;
    prep(1);
    ack_lat = 40;
    pulse_start();
    n = 0;
    while (got_q.size() < 1 && n < 200) begin @(negedge clk); n++; end
    chk("t7_first_handshake", got_q.size(), 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    ack_lat = 2;
    prep(1);
    pulse_start();
    repeat (6) @(negedge clk);
    pulse_start();
    wait_seq_end(800);
    chk("t7_cmd_count", got_q.size(), 2);
    if (got_q.size() == 2) chk("t7_cmd0", 32'(got_q[0]), 32'h1280);
    chk("t7_done", 32'(done), 1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_config_seq.md
Name: cam_config_seq

Overview:
Power-up and register-configuration sequencer for the OV7670 camera, running on the 25 MHz pixel-domain clock. On start it drives the camera power-down and reset pins through a timed power-on sequence. It then walks an external synchronous register ROM of {reg,value} pairs and issues each pair as a write command to the SCCB master, with per-entry retry on NACK. It reports busy/done/error to the top level so capture and VGA output start only after configuration completes.

Parameters:
ADDR_W, 8, ROM address width; the table holds up to 2^ADDR_W entries.
RESET_CYCLES, 25000, clk cycles cam_reset_n is held low after start (1 ms at 25 MHz).
BOOT_CYCLES, 250000, clk cycles waited after cam_reset_n rises, before the first write.
DELAY_CYCLES, 250000, clk cycles waited for each delay-marker entry.
MAX_RETRY, 3, re-issues allowed per entry after NACK before failing.
DEV_ADDR, 8'h42, SCCB write device address driven on cmd_dev.

Ports:
clk  in  1  system clock (25 MHz)
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins the sequence when not busy
rom_addr  out  ADDR_W  ROM read address
rom_data  in  16  {reg[15:8], value[7:0]}; valid one cycle after rom_addr
cmd_valid  out  1  write command valid
cmd_ready  in  1  SCCB master accepts command
cmd_dev  out  8  device address (DEV_ADDR)
cmd_reg  out  8  register address
cmd_val  out  8  register value
wr_done  in  1  one-cycle pulse: transaction finished
wr_nack  in  1  qualifies wr_done; 1 = NACK
cam_reset_n  out  1  OV7670 RESET pin, active-low
cam_pwdn  out  1  OV7670 PWDN pin, active-high
busy  out  1  sequence in progress
done  out  1  level; configuration completed
error  out  1  level; entry failed after retries
fail_addr  out  ADDR_W  ROM address of the failing entry

Behaviour:
- Reset values (asserted asynchronously while reset=0): state IDLE; cam_pwdn=1; cam_reset_n=0; cmd_valid=0; cmd_reg/cmd_val=0; rom_addr=0; busy/done/error=0; fail_addr=0; all counters and the retry count are 0. cmd_dev is constant DEV_ADDR.
- States: IDLE, PWR_RST, BOOT, FETCH, DECODE, ISSUE, WAIT_ACK, DELAY, DONE, FAIL.
- IDLE/DONE/FAIL + start:
  - Next cycle enters PWR_RST with busy=1, done=0, error=0, cam_pwdn=0, cam_reset_n=0, rom_addr=0.
  - start is ignored in every other state.
- PWR_RST: hold for exactly RESET_CYCLES cycles, then go to BOOT with cam_reset_n=1.
- BOOT: hold for exactly BOOT_CYCLES cycles, then go to FETCH.
- FETCH: one cycle; rom_addr is stable. Then DECODE samples rom_data.
- DECODE:
  - 16'hFFFF (end marker) -> DONE.
  - 16'hFFF0 (delay marker) -> DELAY.
  - Otherwise latch cmd_reg/cmd_val, clear the retry count, go to ISSUE.
- ISSUE:
  - cmd_valid=1, with cmd_* held stable until cmd_ready=1 at a clock edge.
  - cmd_valid=0 from the following cycle; state becomes WAIT_ACK.
  - cmd_ready while cmd_valid=0 has no effect.
- WAIT_ACK, on wr_done:
  - ACK -> advance entry.
  - NACK with retry < MAX_RETRY -> retry+1, return to ISSUE with the same data.
  - NACK with retry == MAX_RETRY -> FAIL; fail_addr=rom_addr.
  - wr_done outside WAIT_ACK is ignored.
- DELAY: wait exactly DELAY_CYCLES cycles, then advance entry.
- Advance entry: if rom_addr == 2^ADDR_W-1, go to DONE (no wrap). Otherwise rom_addr+1 and go to FETCH.
- DONE: done=1, busy=0; cam pins stay at pwdn=0, reset_n=1.
- FAIL: error=1, busy=0, cam_pwdn=1. fail_addr holds until the next start.
- Reset mid-sequence returns immediately to reset values; any outstanding SCCB transaction is abandoned.
- Entry-to-entry overhead: 2 cycles (FETCH+DECODE) plus the handshake.

Test Plan:
1. RESET_CYCLES=4, BOOT_CYCLES=8; start pulse -> cam_reset_n low for exactly 4 cycles, rom_addr=0 first presented 8 cycles after cam_reset_n rises, busy=1 throughout.
2. ROM {0x1280, 0x1114, 0xFFFF}, ready/ack model -> exactly two commands, (0x12,0x80) then (0x11,0x14); done=1 after the end marker; busy=0; no third cmd_valid.
3. Delay entry: ROM {0xFFF0, 0x3A04, 0xFFFF}, DELAY_CYCLES=10 -> 10-cycle gap from DECODE of entry 0 to rom_addr=1; then one write (0x3A,0x04).
4. cmd_ready held low for 5 cycles -> cmd_valid and cmd_reg/cmd_val stable all 5 cycles; deasserted the cycle after the handshake.
5. NACK twice then ACK, MAX_RETRY=3 -> same command issued 3 times, then advance. Always NACK -> 4 issues; error=1; fail_addr=entry index; cam_pwdn=1.
6. Reset asserted in WAIT_ACK -> all outputs at reset values asynchronously; start after release reruns from rom_addr=0. Start while busy -> no effect.
